// File: rtl/iob2axil_seq_pkg.sv
// Shared constants for the registered IOb to AXI4-Lite master bridge:
// FSM state encodings, AXI response codes and the default protection value.
package iob2axil_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WRITE   = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_READ_A  = 3'd3;
    localparam logic [2:0] ST_READ_D  = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam logic [2:0] PROT_DEFAULT = 3'd2;

endpackage

// File: rtl/iob2axil_seq_ch.sv
// Generic "hold valid until ready" channel register: load captures the payload
// and raises valid; valid drops on its own handshake and a sticky done flag is kept.
module iob2axil_seq_ch #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         done_o
);

    logic         valid_q, valid_d;
    logic         done_q, done_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            done_d  = 1'b0;
            data_d  = data_i;
        end else begin
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
            if (clr_i) done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    // Done includes a handshake completing this very cycle.
    assign done_o  = done_q | (valid_q & ready_i);

endmodule

// File: rtl/iob2axil_seq.sv
// Registered IOb to AXI4-Lite master bridge with optional posted writes.
// Define IOB2AXIL_SEQ_ERR_EN to add sticky response-error reporting ports.
module iob2axil_seq
    import iob2axil_seq_pkg::*;
#(
    parameter int         ADDR_W       = 32,
    parameter int         DATA_W       = 32,
    parameter logic [2:0] PROT         = PROT_DEFAULT,
    parameter int         WRITE_POSTED = 0,
    parameter int         OUTS_W       = 4
) (
    input  logic                clk_i,
    input  logic                arst_i,
`ifdef IOB2AXIL_SEQ_ERR_EN
    input  logic                err_clr_i,
    output logic                err_o,
    output logic [1:0]          err_resp_o,
`endif
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                axil_awvalid_o,
    input  logic                axil_awready_i,
    output logic [ADDR_W-1:0]   axil_awaddr_o,
    output logic [2:0]          axil_awprot_o,
    output logic                axil_wvalid_o,
    input  logic                axil_wready_i,
    output logic [DATA_W-1:0]   axil_wdata_o,
    output logic [DATA_W/8-1:0] axil_wstrb_o,
    input  logic                axil_bvalid_i,
    output logic                axil_bready_o,
    input  logic [1:0]          axil_bresp_i,
    output logic                axil_arvalid_o,
    input  logic                axil_arready_i,
    output logic [ADDR_W-1:0]   axil_araddr_o,
    output logic [2:0]          axil_arprot_o,
    input  logic                axil_rvalid_i,
    output logic                axil_rready_o,
    input  logic [DATA_W-1:0]   axil_rdata_i,
    input  logic [1:0]          axil_rresp_i
);

    localparam bit                POSTED  = (WRITE_POSTED != 0);
    localparam logic [OUTS_W-1:0] CNT_MAX = '1;
    localparam logic [OUTS_W-1:0] CNT_ONE = {{(OUTS_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [OUTS_W-1:0] cnt_q, cnt_d;
    logic              bready_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic is_wr, admit, accept, wr_both, b_hs, r_hs;
    logic aw_done, w_done, ar_done;

    // Reads wait for every outstanding B so they never overtake a posted write.
    assign is_wr   = |iob_wstrb_i;
    assign admit   = is_wr ? (cnt_q != CNT_MAX) : (cnt_q == '0);
    assign iob_ready_o = ~arst_i & (state_q == ST_IDLE) & admit;
    assign accept  = iob_avalid_i & iob_ready_o;
    assign wr_both = (state_q == ST_WRITE) & aw_done & w_done;
    assign b_hs    = axil_bvalid_i & axil_bready_o;
    assign r_hs    = axil_rvalid_i & axil_rready_o;

    iob2axil_seq_ch #(.W(ADDR_W)) u_aw (
        .clk_i(clk_i), .arst_i(arst_i),
        .load_i(accept & is_wr), .clr_i(wr_both),
        .data_i(iob_addr_i), .ready_i(axil_awready_i),
        .valid_o(axil_awvalid_o), .data_o(axil_awaddr_o), .done_o(aw_done)
    );

    iob2axil_seq_ch #(.W(DATA_W + DATA_W/8)) u_w (
        .clk_i(clk_i), .arst_i(arst_i),
        .load_i(accept & is_wr), .clr_i(wr_both),
        .data_i({iob_wstrb_i, iob_wdata_i}), .ready_i(axil_wready_i),
        .valid_o(axil_wvalid_o), .data_o({axil_wstrb_o, axil_wdata_o}), .done_o(w_done)
    );

    iob2axil_seq_ch #(.W(ADDR_W)) u_ar (
        .clk_i(clk_i), .arst_i(arst_i),
        .load_i(accept & ~is_wr), .clr_i(ar_done & (state_q == ST_READ_A)),
        .data_i(iob_addr_i), .ready_i(axil_arready_i),
        .valid_o(axil_arvalid_o), .data_o(axil_araddr_o), .done_o(ar_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept)  state_d = is_wr ? ST_WRITE : ST_READ_A;
            ST_WRITE:   if (wr_both) state_d = POSTED ? ST_IDLE : ST_WR_RESP;
            ST_WR_RESP: if (b_hs)    state_d = ST_IDLE;
            ST_READ_A:  if (ar_done) state_d = ST_READ_D;
            ST_READ_D:  if (r_hs)    state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Stray B responses with nothing outstanding leave the counter at zero.
    always_comb begin
        cnt_d = cnt_q;
        case ({POSTED & wr_both, POSTED & b_hs & (cnt_q != '0)})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bready_q <= POSTED;
            rvalid_q <= r_hs;
            if (r_hs) rdata_q <= axil_rdata_i;
        end
    end

    assign axil_bready_o = bready_q | (state_q == ST_WR_RESP);
    assign axil_rready_o = (state_q == ST_READ_D);
    assign axil_awprot_o = PROT;
    assign axil_arprot_o = PROT;
    assign iob_rvalid_o  = rvalid_q;
    assign iob_rdata_o   = rdata_q;

`ifdef IOB2AXIL_SEQ_ERR_EN
    logic       err_q, err_d;
    logic [1:0] err_resp_q, err_resp_d;
    logic       r_err, b_err;

    assign r_err = r_hs & (axil_rresp_i != RESP_OKAY);
    assign b_err = b_hs & (axil_bresp_i != RESP_OKAY);

    // A new error in the clearing cycle survives and becomes the first code.
    always_comb begin
        err_d      = err_q;
        err_resp_d = err_resp_q;
        if (r_err || b_err) begin
            err_d = 1'b1;
            if (!err_q || err_clr_i) err_resp_d = r_err ? axil_rresp_i : axil_bresp_i;
        end else if (err_clr_i) begin
            err_d      = 1'b0;
            err_resp_d = RESP_OKAY;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            err_q      <= 1'b0;
            err_resp_q <= RESP_OKAY;
        end else begin
            err_q      <= err_d;
            err_resp_q <= err_resp_d;
        end
    end

    assign err_o      = err_q;
    assign err_resp_o = err_resp_q;
`else
    logic unused_resp;
    assign unused_resp = ^{axil_bresp_i, axil_rresp_i};
`endif

endmodule

// File: tb/tb_iob2axil_seq.sv
// Directed bench: a non-posted bridge and a posted (OUTS_W=2) bridge share one
// stimulus set; each scenario checks the instance it targets.
module tb_iob2axil_seq;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        avalid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'd0, rresp = 2'd0;
    logic [31:0] rdata = '0;
    logic        err_clr = 1'b0;

    logic        n_ready, n_rvalid, n_awvalid, n_wvalid, n_bready, n_arvalid, n_rready;
    logic [31:0] n_rdata, n_awaddr, n_wdata, n_araddr;
    logic [3:0]  n_wstrb;
    logic [2:0]  n_awprot, n_arprot;
    logic        p_ready, p_rvalid, p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
    logic [31:0] p_rdata, p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    logic [2:0]  p_awprot, p_arprot;
`ifdef IOB2AXIL_SEQ_ERR_EN
    logic        n_err, p_err;
    logic [1:0]  n_err_resp, p_err_resp;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iob2axil_seq dut_n (
        .clk_i(clk), .arst_i(arst),
`ifdef IOB2AXIL_SEQ_ERR_EN
        .err_clr_i(err_clr), .err_o(n_err), .err_resp_o(n_err_resp),
`endif
        .iob_avalid_i(avalid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_ready_o(n_ready), .iob_rvalid_o(n_rvalid), .iob_rdata_o(n_rdata),
        .axil_awvalid_o(n_awvalid), .axil_awready_i(awready), .axil_awaddr_o(n_awaddr),
        .axil_awprot_o(n_awprot), .axil_wvalid_o(n_wvalid), .axil_wready_i(wready),
        .axil_wdata_o(n_wdata), .axil_wstrb_o(n_wstrb), .axil_bvalid_i(bvalid),
        .axil_bready_o(n_bready), .axil_bresp_i(bresp), .axil_arvalid_o(n_arvalid),
        .axil_arready_i(arready), .axil_araddr_o(n_araddr), .axil_arprot_o(n_arprot),
        .axil_rvalid_i(rvalid), .axil_rready_o(n_rready), .axil_rdata_i(rdata),
        .axil_rresp_i(rresp)
    );

    iob2axil_seq #(.WRITE_POSTED(1), .OUTS_W(2)) dut_p (
        .clk_i(clk), .arst_i(arst),
`ifdef IOB2AXIL_SEQ_ERR_EN
        .err_clr_i(err_clr), .err_o(p_err), .err_resp_o(p_err_resp),
`endif
        .iob_avalid_i(avalid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_ready_o(p_ready), .iob_rvalid_o(p_rvalid), .iob_rdata_o(p_rdata),
        .axil_awvalid_o(p_awvalid), .axil_awready_i(awready), .axil_awaddr_o(p_awaddr),
        .axil_awprot_o(p_awprot), .axil_wvalid_o(p_wvalid), .axil_wready_i(wready),
        .axil_wdata_o(p_wdata), .axil_wstrb_o(p_wstrb), .axil_bvalid_i(bvalid),
        .axil_bready_o(p_bready), .axil_bresp_i(bresp), .axil_arvalid_o(p_arvalid),
        .axil_arready_i(arready), .axil_araddr_o(p_araddr), .axil_arprot_o(p_arprot),
        .axil_rvalid_i(rvalid), .axil_rready_o(p_rready), .axil_rdata_i(rdata),
        .axil_rresp_i(rresp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_n_ready", 32'(n_ready), 0);
        chk("rst_n_awvalid", 32'(n_awvalid), 0);
        chk("rst_n_arvalid", 32'(n_arvalid), 0);
        chk("rst_n_rdata", n_rdata, 0);
        chk("rst_p_bready", 32'(p_bready), 0);
        arst = 1'b0;
        step();
        chk("post_rst_p_bready", 32'(p_bready), 1);
        chk("post_rst_n_bready", 32'(n_bready), 0);
        chk("post_rst_n_ready", 32'(n_ready), 1);

        // Read, zero-wait slave
        avalid = 1'b1; addr = 32'h100; wstrb = 4'h0; #1;
        chk("rd_ready", 32'(n_ready), 1);
        step(); avalid = 1'b0;
        chk("rd_arvalid", 32'(n_arvalid), 1);
        chk("rd_araddr", n_araddr, 32'h100);
        chk("rd_arprot", 32'(n_arprot), 2);
        chk("rd_busy", 32'(n_ready), 0);
        arready = 1'b1;
        step(); arready = 1'b0;
        chk("rd_ar_drop", 32'(n_arvalid), 0);
        chk("rd_rready", 32'(n_rready), 1);
        rvalid = 1'b1; rdata = 32'hDEADBEEF;
        step(); rvalid = 1'b0; rdata = '0; #1;
        chk("rd_rvalid", 32'(n_rvalid), 1);
        chk("rd_rdata", n_rdata, 32'hDEADBEEF);
        chk("rd_idle_ready", 32'(n_ready), 1);
        step();
        chk("rd_rvalid_pulse", 32'(n_rvalid), 0);
        chk("rd_rdata_hold", n_rdata, 32'hDEADBEEF);

        // Non-posted write, awready late by 3, wready immediately
        avalid = 1'b1; addr = 32'h200; wdata = 32'h12345678; wstrb = 4'hF; #1;
        chk("wr_ready", 32'(n_ready), 1);
        step(); avalid = 1'b0; wstrb = 4'h0;
        chk("wr_awvalid_c1", 32'(n_awvalid), 1);
        chk("wr_wvalid_c1", 32'(n_wvalid), 1);
        chk("wr_wdata", n_wdata, 32'h12345678);
        chk("wr_wstrb", 32'(n_wstrb), 32'hF);
        wready = 1'b1;
        step(); wready = 1'b0;
        chk("wr_wvalid_drop", 32'(n_wvalid), 0);
        chk("wr_awvalid_c2", 32'(n_awvalid), 1);
        step();
        chk("wr_awvalid_c3", 32'(n_awvalid), 1);
        chk("wr_awaddr_c3", n_awaddr, 32'h200);
        awready = 1'b1;
        step(); awready = 1'b0;
        chk("wr_awvalid_drop", 32'(n_awvalid), 0);
        chk("wr_bready", 32'(n_bready), 1);
        chk("wr_wait_b", 32'(n_ready), 0);
        step();
        chk("wr_still_wait_b", 32'(n_ready), 0);
        bvalid = 1'b1;
        step(); bvalid = 1'b0; #1;
        chk("wr_done_ready", 32'(n_ready), 1);
        chk("wr_bready_drop", 32'(n_bready), 0);

        // Posted, OUTS_W=2, B withheld: three writes admitted, fourth blocked
        awready = 1'b1; wready = 1'b1;
        avalid = 1'b1; addr = 32'h300; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_admit", 32'(p_ready), 1);
            step();
            chk("post_awvalid", 32'(p_awvalid), 1);
            step();
        end
        #1;
        chk("post_full_block", 32'(p_ready), 0);
        step();
        chk("post_full_block2", 32'(p_ready), 0);
        chk("post_no_stray_aw", 32'(p_awvalid), 0);
        bvalid = 1'b1;
        step(); bvalid = 1'b0; #1;
        chk("post_4th_admit", 32'(p_ready), 1);
        step();
        chk("post_4th_awvalid", 32'(p_awvalid), 1);
        step(); avalid = 1'b0;

        // Posted read blocked until all three B responses drain
        avalid = 1'b1; addr = 32'h400; wstrb = 4'h0; #1;
        chk("rdaw_block0", 32'(p_ready), 0);
        bvalid = 1'b1;
        step();
        chk("rdaw_block1", 32'(p_ready), 0);
        chk("rdaw_no_ar", 32'(p_arvalid), 0);
        step();
        chk("rdaw_block2", 32'(p_ready), 0);
        step(); bvalid = 1'b0; #1;
        chk("rdaw_admit", 32'(p_ready), 1);
        step(); avalid = 1'b0;
        chk("rdaw_arvalid", 32'(p_arvalid), 1);
        chk("rdaw_araddr", p_araddr, 32'h400);

        // Asynchronous reset while arvalid is held
        awready = 1'b0; wready = 1'b0;
        arst = 1'b1; #1;
        chk("arst_arvalid", 32'(p_arvalid), 0);
        chk("arst_ready", 32'(p_ready), 0);
        chk("arst_bready", 32'(p_bready), 0);
        chk("arst_rdata", p_rdata, 0);
        step(); arst = 1'b0;
        step();
        avalid = 1'b1; addr = 32'h500; wstrb = 4'h0; #1;
        chk("rearm_ready", 32'(p_ready), 1);
        step(); avalid = 1'b0;
        chk("rearm_araddr", p_araddr, 32'h500);
        arready = 1'b1;
        step(); arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFE0001;
        step(); rvalid = 1'b0; #1;
        chk("rearm_rvalid", 32'(p_rvalid), 1);
        chk("rearm_rdata", p_rdata, 32'hCAFE0001);

`ifdef IOB2AXIL_SEQ_ERR_EN
        // Sticky error: SLVERR read, then DECERR B keeps the first code
        step();
        avalid = 1'b1; addr = 32'h600; wstrb = 4'h0;
        step(); avalid = 1'b0; arready = 1'b1;
        step(); arready = 1'b0; rvalid = 1'b1; rresp = 2'd2;
        step(); rvalid = 1'b0; rresp = 2'd0; #1;
        chk("err_set", 32'(p_err), 1);
        chk("err_code_r", 32'(p_err_resp), 2);
        bvalid = 1'b1; bresp = 2'd3;
        step(); bvalid = 1'b0; bresp = 2'd0; #1;
        chk("err_keep", 32'(p_err), 1);
        chk("err_keep_code", 32'(p_err_resp), 2);
        err_clr = 1'b1;
        step(); err_clr = 1'b0; #1;
        chk("err_clr", 32'(p_err), 0);
        chk("err_clr_code", 32'(p_err_resp), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iob2axil_seq.md
Name: iob2axil_seq

Overview:
- Registered, handshake-correct successor of the combinational IOb-to-AXI4-Lite master bridge.
- Captures each IOb request and drives the AW, W and AR channels independently until each is accepted.
- Tracks B responses; optional posted-write mode keeps up to 2^OUTS_W-1 write responses outstanding.
- Sits between a CPU/DMA IOb master and the AXI-Lite peripheral interconnect.

Parameters:
- ADDR_W, 32, IOb/AXI-Lite address width (AXIL_ADDR_W = ADDR_W).
- DATA_W, 32, IOb/AXI-Lite data width (AXIL_DATA_W = DATA_W); multiple of 8.
- PROT, 3'd2, constant value driven on awprot/arprot.
- WRITE_POSTED, 0, 0: IOb write completes after B; 1: completes after AW and W are both accepted.
- OUTS_W, 4, width of the outstanding-B counter; maximum outstanding = 2^OUTS_W-1.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous reset, active-high
- iob_avalid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  request address
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  write strobes; 0 = read
- iob_ready_o  out  1  request accepted when high with avalid
- iob_rvalid_o  out  1  one-cycle read-data valid
- iob_rdata_o  out  DATA_W  read data
- axil_aw*, axil_w*, axil_b*, axil_ar*, axil_r*: full AXI4-Lite master set (awvalid/awready/awaddr/awprot, wvalid/wready/wdata/wstrb, bvalid/bready/bresp, arvalid/arready/araddr/arprot, rvalid/rready/rdata/rresp), standard directions and widths.

Behaviour:
- Clock and reset: single clock clk_i; asynchronous active-high reset arst_i.
- Reset values: all AXI valids 0, bready 0, rready 0, iob_rvalid_o 0, iob_rdata_o 0, iob_ready_o 0, counter 0, FSM in IDLE.
- FSM states: IDLE, WRITE, WR_RESP, READ_A, READ_D.
- iob_ready_o is combinational: (state==IDLE) & admit.
  - admit for a write = counter < 2^OUTS_W-1.
  - admit for a read = counter == 0, so a read never overtakes an outstanding write.
- Capture: on avalid & ready, register addr, wdata and wstrb. Go to WRITE if |wstrb, else READ_A.
- WRITE state:
  - awvalid and wvalid are asserted from the next cycle, with flags aw_done and w_done.
  - Each valid is held with stable payload until its own ready. Each channel drops independently; same-cycle or either-order acceptance is legal.
  - When both flags are set: WRITE_POSTED=0 goes to WR_RESP; WRITE_POSTED=1 goes to IDLE.
  - Flags clear on exit.
- WR_RESP (non-posted only): bready=1 and wait for bvalid, then go to IDLE. bresp is ignored unless the optional feature is enabled.
- Posted mode:
  - bready is constantly 1 after reset.
  - The counter increments when both AW and W complete and decrements on bvalid.
  - A simultaneous increment and decrement leaves the counter unchanged.
  - The counter never wraps because admit blocks at the maximum.
- READ_A: arvalid is held with stable araddr until arready, then go to READ_D.
- READ_D: rready=1. On rvalid, register rdata into iob_rdata_o, pulse iob_rvalid_o for exactly one cycle (the cycle after the R handshake), and return to IDLE.
- iob_rdata_o holds its last value between reads.
- Minimum latency:
  - Read: accept → arvalid +1 → R handshake ≥ +2 → iob_rvalid_o +1.
  - Write with zero-wait slave: ready again 2 cycles after accept (posted) or 3 cycles (non-posted).
- Reset mid-transaction deasserts all valids immediately. The AXI slave must be reset in the same domain.
- The bridge never generates a valid without a captured request. A stray bvalid with counter 0 in posted mode is ignored and the counter saturates at 0.

Optional Feature:
- Macro IOB2AXIL_SEQ_ERR_EN adds outputs err_o (1) and err_resp_o (2) and input err_clr_i (1).
- With the macro: err_o is set sticky by any bresp or rresp ≠ OKAY and captures the first non-OKAY code. err_clr_i clears both; a set in the same cycle as a clear wins.
- Without the macro: these ports are absent and responses are discarded.

Decomposition:
- Shared package/header iob2axil_seq_pkg holds:
  - FSM state encodings (3-bit).
  - AXI response constants OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - Default PROT value.
- One natural sub-module, iob2axil_seq_ch: a generic "hold valid until ready" channel register. It is instantiated for AW, W and AR.

Test Plan:
- Read, zero-wait slave: request addr 0x100, rdata 0xDEADBEEF → araddr 0x100, iob_rvalid_o one cycle with 0xDEADBEEF, ready back in IDLE the same cycle.
- Write with awready delayed 3 cycles and wready delayed 1: wstrb 0xF, data 0x12345678 → wvalid drops after 1 cycle, awvalid held 3 cycles, payload stable throughout, one B consumed, WRITE_POSTED=0 completion only after bvalid.
- Posted mode, OUTS_W=2, slave withholds bvalid: 3 writes are accepted, the 4th request sees iob_ready_o=0; one bvalid → 4th accepted next cycle.
- Posted mode read after write with B pending: read is blocked until bvalid drains the counter to 0, then arvalid is issued.
- arst_i asserted mid-READ_A with arvalid high → arvalid 0 asynchronously, all outputs at reset values, first request after release works normally.
- IOB2AXIL_SEQ_ERR_EN: rresp=SLVERR on a read, then bresp=DECERR → err_o=1, err_resp_o=2 retained; err_clr_i clears to 0.
